// File: rtl/decrypt_v2.sv
// Iterative PRESENT-80 block decryptor (64-bit block, 80-bit key, 31 rounds).
// Latency: ack rises 62 cycles after the latch edge (31 key-expand + 31 inverse rounds).
// Backpressure: four-phase req/ack; a new request is taken only from IDLE, ack holds until req drops.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, overrides every transition
//   req  - request, sampled each edge
//   ack  - registered acknowledge, high while M is valid
//   K    - 80-bit key, sampled only on the latch edge
//   C    - 64-bit ciphertext, sampled only on the latch edge
//   M    - 64-bit registered plaintext, held until the next completed operation or reset

module decrypt_v2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    input  logic [79:0] K,
    input  logic [63:0] C,
    output logic [63:0] M
);

    localparam int unsigned BLK_W  = 64;
    localparam int unsigned KEY_W  = 80;
    localparam logic [4:0]  ROUNDS = 5'd31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Cipher primitives
    // ------------------------------------------------------------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] inv_sbox_layer(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = inv_sbox(s[4*n +: 4]);
        end
        return o;
    endfunction

    // Forward pLayer sends bit j to bit 16j mod 63, so the inverse pulls
    // output bit j from input bit 16j mod 63. Bit 63 is a fixed point.
    function automatic logic [BLK_W-1:0] inv_player(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        o = '0;
        for (int j = 0; j < 63; j++) begin
            o[j] = s[(16 * j) % 63];
        end
        o[63] = s[63];
        return o;
    endfunction

    // Forward schedule step: rotate left 61, S-box top nibble, mix counter.
    function automatic logic [KEY_W-1:0] key_upd(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       i);
        logic [KEY_W-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

    // Exact inverse of key_upd: undo the steps in reverse order.
    function automatic logic [KEY_W-1:0] key_inv(input logic [KEY_W-1:0] k,
                                                 input logic [4:0]       i);
        logic [KEY_W-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ i;
        t[79:76]   = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_nxt;
    logic [KEY_W-1:0]   key;
    logic [KEY_W-1:0]   key_nxt;
    logic [BLK_W-1:0]   st;
    logic [BLK_W-1:0]   st_nxt;
    logic [4:0]         cnt;
    logic [4:0]         cnt_nxt;
    logic [BLK_W-1:0]   m_nxt;
    logic               ack_nxt;

    // Datapath for both iterative phases. The schedule runs forward during
    // EXPAND and is unwound one step per inverse round during ROUND.
    logic [KEY_W-1:0]   key_fwd;
    logic [KEY_W-1:0]   key_bwd;
    logic [BLK_W-1:0]   st_rnd;

    assign key_fwd = key_upd(key, cnt);
    assign key_bwd = key_inv(key, cnt);
    assign st_rnd  = inv_sbox_layer(inv_player(st)) ^ key_bwd[79:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            key   <= '0;
            st    <= '0;
            cnt   <= '0;
            M     <= '0;
            ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            key   <= key_nxt;
            st    <= st_nxt;
            cnt   <= cnt_nxt;
            M     <= m_nxt;
            ack   <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = key;
        st_nxt    = st;
        cnt_nxt   = cnt;
        m_nxt     = M;
        ack_nxt   = ack;

        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (req) begin
                    key_nxt   = K;
                    st_nxt    = C;
                    cnt_nxt   = 5'd1;
                    state_nxt = EXPAND;
                end
            end

            EXPAND: begin
                key_nxt = key_fwd;
                cnt_nxt = cnt + 5'd1;
                if (cnt == ROUNDS) begin
                    // key_fwd is now the last round key: whiten with it and
                    // keep the counter at 31 to start unwinding from there.
                    st_nxt    = st ^ key_fwd[79:16];
                    cnt_nxt   = ROUNDS;
                    state_nxt = ROUND;
                end
            end

            ROUND: begin
                key_nxt = key_bwd;
                st_nxt  = st_rnd;
                cnt_nxt = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    m_nxt     = st_rnd;
                    ack_nxt   = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                ack_nxt = 1'b1;
                if (!req) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
